// File: rtl/arp_pkg.sv
// ARP protocol constants, FSM encodings and the parsed-field record shared by the rx and tx sides.
// Latency: none (definitions only).
// Backpressure: not applicable.
package arp_pkg;

    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN       = 8'd6;
    localparam logic [7:0]  ARP_PLEN       = 8'd4;
    localparam logic [15:0] ARP_OP_REQUEST = 16'd1;
    localparam logic [15:0] ARP_OP_REPLY   = 16'd2;
    localparam int          ARP_WORDS      = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2
    } arp_state_t;

    // Field order mirrors the wire order, so 7 concatenated words cast straight onto it.
    typedef struct packed {
        logic [15:0] hdr_type;
        logic [15:0] proto_type;
        logic [7:0]  hdr_addr_length;
        logic [7:0]  pro_addr_length;
        logic [15:0] operation;
        logic [47:0] send_hdr_addr;
        logic [31:0] send_ip_addr;
        logic [47:0] target_hdr_addr;
        logic [31:0] target_ip_addr;
    } arp_fields_t;

    function automatic arp_fields_t arp_unpack(
        input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
        input logic [31:0] w3, input logic [31:0] w4, input logic [31:0] w5,
        input logic [31:0] w6
    );
        return arp_fields_t'({w0, w1, w2, w3, w4, w5, w6});
    endfunction

endpackage

// File: rtl/arp_hdr_check.sv
// Validates the fixed ARP header fields for Ethernet/IPv4 request or reply.
// Latency: combinational.
// Backpressure: none.
module arp_hdr_check
    import arp_pkg::*;
(
    input  logic [15:0] hdr_type,
    input  logic [15:0] proto_type,
    input  logic [7:0]  hdr_addr_length,
    input  logic [7:0]  pro_addr_length,
    input  logic [15:0] operation,
    output logic        frame_ok
);

    always_comb begin
        frame_ok = (hdr_type == ARP_HTYPE_ETH)
                 & (proto_type == ARP_PTYPE_IPV4)
                 & (hdr_addr_length == ARP_HLEN)
                 & (pro_addr_length == ARP_PLEN)
                 & ((operation == ARP_OP_REQUEST) | (operation == ARP_OP_REPLY));
    end

endmodule

// File: rtl/arp_receive.sv
// Reassembles a 7-word ARP frame into named fields, checks the header and matches the target IP.
// Latency: output_valid/frame_error one cycle after the last/missing word is sampled.
// Backpressure: none; the stream is assumed paced by the transmitter, extra words are dropped.
module arp_receive
    import arp_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP = 32'hC0A8_0001,
    parameter int          WORDS    = ARP_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_receive,
    input  logic        input_valid,
    output logic [15:0] hdr_type,
    output logic [15:0] proto_type,
    output logic [7:0]  hdr_addr_length,
    output logic [7:0]  pro_addr_length,
    output logic [15:0] operation,
    output logic [47:0] send_hdr_addr,
    output logic [31:0] send_ip_addr,
    output logic [47:0] target_hdr_addr,
    output logic [31:0] target_ip_addr,
    output logic        output_valid,
    output logic        frame_ok,
    output logic        ip_match,
    output logic        frame_error,
    output logic        busy
);

    localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

    arp_state_t  state;
    logic [2:0]  cnt;
    logic [31:0] shadow [0:5];
    arp_fields_t fields;
    arp_fields_t fields_nxt;
    logic        hdr_ok_nxt;

    assign fields_nxt = arp_unpack(shadow[0], shadow[1], shadow[2], shadow[3],
                                   shadow[4], shadow[5], input_receive);

    arp_hdr_check u_hdr_check (
        .hdr_type        (fields_nxt.hdr_type),
        .proto_type      (fields_nxt.proto_type),
        .hdr_addr_length (fields_nxt.hdr_addr_length),
        .pro_addr_length (fields_nxt.pro_addr_length),
        .operation       (fields_nxt.operation),
        .frame_ok        (hdr_ok_nxt)
    );

    // Shadow words carry no reset: they are only consumed after a full frame rewrites them.
    always_ff @(posedge clk) begin
        if (input_valid) begin
            if (state == ST_IDLE)
                shadow[0] <= input_receive;
            else if (state == ST_RECV && cnt != LAST_IDX)
                shadow[cnt] <= input_receive;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            fields       <= '0;
            output_valid <= 1'b0;
            frame_ok     <= 1'b0;
            ip_match     <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            output_valid <= 1'b0;
            frame_error  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (input_valid) begin
                        cnt   <= 3'd1;
                        state <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (input_valid) begin
                        if (cnt == LAST_IDX) begin
                            fields       <= fields_nxt;
                            frame_ok     <= hdr_ok_nxt;
                            ip_match     <= (input_receive == LOCAL_IP);
                            output_valid <= 1'b1;
                            cnt          <= '0;
                            state        <= ST_DRAIN;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end else begin
                        frame_error <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (!input_valid)
                        state <= ST_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy            = (state != ST_IDLE);
    assign hdr_type        = fields.hdr_type;
    assign proto_type      = fields.proto_type;
    assign hdr_addr_length = fields.hdr_addr_length;
    assign pro_addr_length = fields.pro_addr_length;
    assign operation       = fields.operation;
    assign send_hdr_addr   = fields.send_hdr_addr;
    assign send_ip_addr    = fields.send_ip_addr;
    assign target_hdr_addr = fields.target_hdr_addr;
    assign target_ip_addr  = fields.target_ip_addr;

endmodule

// File: tb/tb_arp_receive.sv
// Directed bench for arp_receive: inputs driven on the falling edge, outputs checked there too.
module tb_arp_receive;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_receive = '0;
    logic        input_valid = 1'b0;
    logic [15:0] hdr_type;
    logic [15:0] proto_type;
    logic [7:0]  hdr_addr_length;
    logic [7:0]  pro_addr_length;
    logic [15:0] operation;
    logic [47:0] send_hdr_addr;
    logic [31:0] send_ip_addr;
    logic [47:0] target_hdr_addr;
    logic [31:0] target_ip_addr;
    logic        output_valid;
    logic        frame_ok;
    logic        ip_match;
    logic        frame_error;
    logic        busy;

    int total = 0;
    int bad   = 0;

    arp_receive dut (
        .clk             (clk),
        .rst             (rst),
        .input_receive   (input_receive),
        .input_valid     (input_valid),
        .hdr_type        (hdr_type),
        .proto_type      (proto_type),
        .hdr_addr_length (hdr_addr_length),
        .pro_addr_length (pro_addr_length),
        .operation       (operation),
        .send_hdr_addr   (send_hdr_addr),
        .send_ip_addr    (send_ip_addr),
        .target_hdr_addr (target_hdr_addr),
        .target_ip_addr  (target_ip_addr),
        .output_valid    (output_valid),
        .frame_ok        (frame_ok),
        .ip_match        (ip_match),
        .frame_error     (frame_error),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    localparam logic [223:0] FRAME_A = {32'h0001_0800, 32'h0604_0001, 32'h0011_2233,
                                        32'h4455_C0A8, 32'h0002_0000, 32'h0000_0000,
                                        32'hC0A8_0001};
    localparam logic [223:0] FRAME_B = {32'h0006_0800, 32'h0604_0001, 32'h0011_2233,
                                        32'h4455_C0A8, 32'h0002_0000, 32'h0000_0000,
                                        32'hC0A8_0001};
    localparam logic [223:0] FRAME_C = {32'h0001_0800, 32'h0604_0002, 32'h1111_1111,
                                        32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                                        32'h5555_5555};
    localparam logic [223:0] FRAME_D = {32'h0001_0800, 32'h0604_0002, 32'h0011_2233,
                                        32'h4455_C0A8, 32'h0002_AABB, 32'hCCDD_EEFF,
                                        32'hC0A8_00FE};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives words [first, first+n) of a frame, one per cycle, valid held high.
    task automatic drive_words(input logic [223:0] f, input int first, input int n);
        logic [223:0] fv;
        fv = f;
        for (int i = first; i < first + n; i++) begin
            @(negedge clk);
            input_receive = fv[223 - 32*i -: 32];
            input_valid   = 1'b1;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        input_valid   = 1'b0;
        input_receive = '0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ovld", output_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_fok", frame_ok, 0);
        chk("rst_htype", hdr_type, 0);
        chk("rst_tpa", target_ip_addr, 0);
        rst = 1'b0;

        // Frame A: good request addressed to us
        drive_words(FRAME_A, 0, 2);
        chk("a_busy_recv", busy, 1);
        drive_words(FRAME_A, 2, 5);
        chk("a_ovld_early", output_valid, 0);
        idle_cycle();
        chk("a_ovld", output_valid, 1);
        chk("a_fok", frame_ok, 1);
        chk("a_ipm", ip_match, 1);
        chk("a_sha", send_hdr_addr, 64'h0011_2233_4455);
        chk("a_spa", send_ip_addr, 32'hC0A8_0002);
        chk("a_op", operation, 1);
        chk("a_htype", hdr_type, 16'h0001);
        chk("a_ptype", proto_type, 16'h0800);
        chk("a_tha", target_hdr_addr, 0);
        chk("a_tpa", target_ip_addr, 32'hC0A8_0001);
        chk("a_ferr", frame_error, 0);
        chk("a_busy_drain", busy, 1);
        idle_cycle();
        chk("a_ovld_pulse", output_valid, 0);
        chk("a_busy_idle", busy, 0);

        // Frame B: bad hardware type, fields still update
        drive_words(FRAME_B, 0, 7);
        idle_cycle();
        chk("b_ovld", output_valid, 1);
        chk("b_fok", frame_ok, 0);
        chk("b_htype", hdr_type, 16'h0006);
        chk("b_ipm", ip_match, 1);
        idle_cycle();

        // Frame C truncated after 4 words
        drive_words(FRAME_C, 0, 4);
        idle_cycle();
        chk("c_ferr_early", frame_error, 0);
        idle_cycle();
        chk("c_ferr", frame_error, 1);
        chk("c_ovld", output_valid, 0);
        chk("c_htype_kept", hdr_type, 16'h0006);
        chk("c_op_kept", operation, 1);
        chk("c_sha_kept", send_hdr_addr, 64'h0011_2233_4455);
        chk("c_busy", busy, 0);
        idle_cycle();
        chk("c_ferr_pulse", frame_error, 0);

        // Frame A with valid held for 9 cycles, then frame D after one idle cycle
        drive_words(FRAME_A, 0, 7);
        drive_words(FRAME_C, 0, 1);
        chk("l_ovld", output_valid, 1);
        chk("l_htype", hdr_type, 16'h0001);
        drive_words(FRAME_C, 1, 1);
        chk("l_ovld_once", output_valid, 0);
        chk("l_busy", busy, 1);
        idle_cycle();
        chk("l_ovld_none", output_valid, 0);
        chk("l_ferr_none", frame_error, 0);
        drive_words(FRAME_D, 0, 7);
        idle_cycle();
        chk("d_ovld", output_valid, 1);
        chk("d_fok", frame_ok, 1);
        chk("d_ipm", ip_match, 0);
        chk("d_op", operation, 2);
        chk("d_tha", target_hdr_addr, 64'hAABB_CCDD_EEFF);
        chk("d_tpa", target_ip_addr, 32'hC0A8_00FE);
        idle_cycle();

        // Reset asserted while word 3 is on the bus
        drive_words(FRAME_A, 0, 3);
        drive_words(FRAME_A, 3, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        input_valid = 1'b0;
        chk("r_htype", hdr_type, 0);
        chk("r_tpa", target_ip_addr, 0);
        chk("r_fok", frame_ok, 0);
        chk("r_ipm", ip_match, 0);
        chk("r_busy", busy, 0);
        chk("r_ovld", output_valid, 0);
        idle_cycle();
        chk("r_ferr", frame_error, 0);
        chk("r_ovld2", output_valid, 0);
        drive_words(FRAME_A, 0, 7);
        idle_cycle();
        chk("r2_ovld", output_valid, 1);
        chk("r2_fok", frame_ok, 1);
        chk("r2_ipm", ip_match, 1);
        chk("r2_spa", send_ip_addr, 32'hC0A8_0002);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arp_receive.md
Name: arp_receive

Overview:
- Downstream consumer of the ARP transmit serializer.
- Accepts the 7-word, 32-bit-per-cycle ARP frame stream (data + valid), reassembles the 28-byte ARP payload into its named fields, validates the fixed header, and flags whether the frame targets the local IP.
- Presents parsed fields with a one-cycle completion strobe to the ARP cache/reply logic.

Parameters:
- LOCAL_IP, 32'hC0A8_0001, IPv4 address of this node; used for ip_match.
- WORDS, 7, number of 32-bit words per ARP frame; fixed by protocol, not to be overridden.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- input_receive  in  32  frame word, valid when input_valid=1
- input_valid  in  1  word strobe; high for consecutive cycles of one frame
- hdr_type  out  16  hardware type (word0[31:16])
- proto_type  out  16  protocol type (word0[15:0])
- hdr_addr_length  out  8  word1[31:24]
- pro_addr_length  out  8  word1[23:16]
- operation  out  16  word1[15:0]
- send_hdr_addr  out  48  {word2, word3[31:16]}
- send_ip_addr  out  32  {word3[15:0], word4[31:16]}
- target_hdr_addr  out  48  {word4[15:0], word5}
- target_ip_addr  out  32  word6
- output_valid  out  1  one-cycle pulse: field outputs updated with a complete frame
- frame_ok  out  1  header checks passed; qualified by output_valid
- ip_match  out  1  target_ip_addr == LOCAL_IP; qualified by output_valid
- frame_error  out  1  one-cycle pulse: frame truncated (valid dropped before word 7)
- busy  out  1  high while in RECV or DRAIN

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=IDLE, word counter=0, all field outputs 0, output_valid/frame_ok/ip_match/frame_error/busy=0. Reset mid-frame discards partial data with no strobes.
- FSM states: IDLE, RECV, DRAIN.
- IDLE: input_valid=1 -> capture word0 into shadow register, counter=1, go RECV.
- RECV: input_valid=1 -> capture word[counter], counter+1. When the captured word is word6 (counter==6), go DRAIN, load all field outputs from shadow + word6, compute frame_ok/ip_match, and assert output_valid on the next cycle (latency: output_valid high the cycle after word6 is sampled).
- RECV with input_valid=0 before word6 -> frame_error pulse next cycle, shadow discarded, outputs unchanged, counter=0, go IDLE.
- DRAIN: remain while input_valid=1; extra words are ignored (no new frame starts until valid has been low ≥1 cycle). input_valid=0 -> IDLE. Back-to-back frames therefore need ≥1 idle cycle, which the transmitter always provides.
- Field outputs hold their last completed frame until the next completed frame; truncated frames never update them.
- frame_ok = (hdr_type==ARP_HTYPE_ETH) & (proto_type==ARP_PTYPE_IPV4) & (hdr_addr_length==6) & (pro_addr_length==4) & (operation==ARP_OP_REQUEST | operation==ARP_OP_REPLY).
- ip_match is evaluated regardless of frame_ok.
- output_valid and frame_error are mutually exclusive, each exactly one cycle.
- busy = (state != IDLE).

Decomposition:
- Package arp_pkg: ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800, ARP_HLEN=8'd6, ARP_PLEN=8'd4, ARP_OP_REQUEST=16'd1, ARP_OP_REPLY=16'd2, ARP_WORDS=7, FSM state encodings. Shared with the transmitter.
- One sub-module, arp_hdr_check: combinational; takes header fields, returns frame_ok. Reusable by the transmitter-side checker.

Test Plan:
- 7 consecutive words 0001_0800, 0604_0001, 0011_2233, 4455_C0A8, 0002_0000, 0000_0000, C0A8_0001 -> output_valid pulse 1 cycle after word 7; frame_ok=1, ip_match=1, send_hdr_addr=0011_2233_4455, send_ip_addr=C0A8_0002, operation=1.
- Same frame with word0=0006_0800 -> output_valid=1, frame_ok=0, fields updated.
- Valid dropped after word 4 -> frame_error pulse, output_valid stays 0, fields retain the previous frame.
- Valid held high for 9 cycles -> single output_valid after word 7; words 8-9 ignored; next frame after one idle cycle parses correctly.
- rst asserted at word 3 -> all outputs 0, no strobes; next full frame parses normally.
- target_ip=C0A8_00FE, operation=2 -> frame_ok=1, ip_match=0.
